// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: unsigned iterative shift-add multiplier (MULTU) with HI/LO
// result registers, MFHI/MFLO read port and a pipeline stall on HI/LO hazards.
// A multiply takes exactly WIDTH cycles regardless of operand values; HI/LO
// are only written once, on the final iteration, so no partial product leaks.
module multu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_rd,
  input  logic             sel_hi,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [2*WIDTH-1:0] p_r;
  logic [2*WIDTH-1:0] p_next_s;
  logic [WIDTH-1:0]   m_r;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;
  logic               last_step_s;

  // One shift-add iteration: add the multiplicand into the upper half when the
  // current multiplier bit is set, keeping the carry as the new top bit, then
  // shift the whole product right by one.
  function automatic logic [2*WIDTH-1:0] mult_step(
    input logic [2*WIDTH-1:0] p,
    input logic [WIDTH-1:0]   m
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
    if (p[0]) begin
      mult_step = {sum, p[WIDTH-1:1]};
    end else begin
      mult_step = {1'b0, p[2*WIDTH-1:1]};
    end
  endfunction

  assign p_next_s    = mult_step(p_r, m_r);
  assign last_step_s = (state_r == RUN) && (count_r == CW'(WIDTH - 1));

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a start is only accepted while idle, so a start held
  // during a stall is picked up at the first edge after busy drops.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Outputs: busy follows the state, stall holds any HI/LO user while busy,
  // and reads always see the committed registers only.
  always_comb begin
    busy  = (state_r == RUN);
    stall = busy & (start | hilo_rd);
    done  = done_r;
    if (sel_hi) begin
      rd_data = hi_r;
    end else begin
      rd_data = lo_r;
    end
  end

  // Datapath: operand latch, iteration, iteration count, HI/LO commit, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r     <= {(2*WIDTH){1'b0}};
      m_r     <= {WIDTH{1'b0}};
      count_r <= {CW{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      done_r <= last_step_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            m_r     <= a;
            p_r     <= {{WIDTH{1'b0}}, b};
            count_r <= {CW{1'b0}};
          end else begin
            m_r     <= m_r;
          end
        end
        RUN: begin
          p_r     <= p_next_s;
          count_r <= count_r + CW'(1);
          if (last_step_s) begin
            hi_r <= p_next_s[2*WIDTH-1:WIDTH];
            lo_r <= p_next_s[WIDTH-1:0];
          end else begin
            hi_r <= hi_r;
          end
        end
        default: begin
          p_r <= p_r;
        end
      endcase
    end
  end

endmodule
